// File: rtl/mc_stage_sequencer.sv
`timescale 1ns/1ps
// mc_stage_sequencer: steps one instruction token through N_STAGES
// variable-latency stages using valid/finish handshakes. Handles redirect
// flush, halt after retire, an optional wait watchdog, a delayed commit pulse
// and free-running busy-cycle / retire counters.
module mc_stage_sequencer #(
    parameter int N_STAGES     = 4,
    parameter int COMMIT_DELAY = 2,
    parameter int TIMEOUT      = 0,
    parameter int CNT_W        = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        halt_req,
    input  logic [N_STAGES-1:0]         stage_finish,
    input  logic                        flush,
    output logic [N_STAGES-1:0]         stage_valid,
    output logic [$clog2(N_STAGES)-1:0] cur_stage,
    output logic                        busy,
    output logic                        retire,
    output logic                        commit_valid,
    output logic                        flushed,
    output logic                        timeout_err,
    output logic [CNT_W-1:0]            cycle_cnt,
    output logic [CNT_W-1:0]            retire_cnt
);
    localparam int SW   = $clog2(N_STAGES);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0]   LAST   = SW'(N_STAGES - 1);
    // Last WAIT count before the watchdog trips (wait_q counts completed WAIT cycles).
    localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [WD_W-1:0]   wait_q, wait_d;
    logic              retire_q, retire_d;
    logic              flushed_q, flushed_d;
    logic              tout_q, tout_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic              cur_fin;

    assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign cur_stage = stage_q;
    assign cur_fin   = stage_finish[stage_q];

    // One-hot start pulse decoded straight from the state: only in ISSUE.
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_valid
        assign stage_valid[gi] = (state_q == S_ISSUE) && (stage_q == SW'(gi));
    end

    // Next-state logic: handshake advance, flush, retire, halt and watchdog.
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        wait_d    = wait_q;
        retire_d  = 1'b0;
        flushed_d = 1'b0;
        tout_d    = tout_q;
        rcnt_d    = rcnt_q;
        cyc_d     = busy ? (cyc_q + CNT_W'(1)) : cyc_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_ISSUE;
                    stage_d = '0;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (state_q == S_ISSUE) begin
                    wait_d = '0;
                end
                if (cur_fin) begin
                    if (flush) begin
                        // Abandon the instruction; halt_req is honoured here too.
                        flushed_d = 1'b1;
                        stage_d   = '0;
                        state_d   = halt_req ? S_HALT : S_ISSUE;
                    end else if (stage_q == LAST) begin
                        retire_d  = 1'b1;
                        rcnt_d    = rcnt_q + CNT_W'(1);
                        stage_d   = '0;
                        state_d   = halt_req ? S_HALT : S_ISSUE;
                    end else begin
                        stage_d   = stage_q + SW'(1);
                        state_d   = S_ISSUE;
                    end
                end else if (state_q == S_ISSUE) begin
                    state_d = S_WAIT;
                end else if ((TIMEOUT > 0) && (wait_q == WD_MAX)) begin
                    // Stage is stuck: park in HALT with the sticky error set.
                    tout_d  = 1'b1;
                    state_d = S_HALT;
                    stage_d = '0;
                end else begin
                    wait_d = wait_q + WD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            stage_q   <= '0;
            wait_q    <= '0;
            retire_q  <= 1'b0;
            flushed_q <= 1'b0;
            tout_q    <= 1'b0;
            cyc_q     <= '0;
            rcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            wait_q    <= wait_d;
            retire_q  <= retire_d;
            flushed_q <= flushed_d;
            tout_q    <= tout_d;
            cyc_q     <= cyc_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign retire      = retire_q;
    assign flushed     = flushed_q;
    assign timeout_err = tout_q;
    assign cycle_cnt   = cyc_q;
    assign retire_cnt  = rcnt_q;

    // Commit pulse: retire delayed through a plain shift register so that
    // back-to-back retires stay one-to-one.
    if (COMMIT_DELAY == 0) begin : g_cd0
        assign commit_valid = retire_q;
    end else begin : g_cdn
        logic [COMMIT_DELAY-1:0] cdl_q, cdl_d;
        assign cdl_d[0] = retire_q;
        for (genvar gi = 1; gi < COMMIT_DELAY; gi++) begin : g_tap
            assign cdl_d[gi] = cdl_q[gi-1];
        end
        // Delay line; reset drops any commit still in flight.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cdl_q <= '0;
            end else begin
                cdl_q <= cdl_d;
            end
        end
        assign commit_valid = cdl_q[COMMIT_DELAY-1];
    end
endmodule

// File: tb/tb_mc_stage_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for mc_stage_sequencer: two instances (A: watchdog and
// 2-cycle commit, B: 4-bit counters, same-cycle commit, no watchdog).
module tb_mc_stage_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, halt_a, flush_a, start_b, halt_b, flush_b;
    logic [3:0] fin_a, fin_b;
    logic [3:0] sv_a, sv_b;
    logic [1:0] cs_a, cs_b;
    logic busy_a, ret_a, com_a, fl_a, to_a;
    logic busy_b, ret_b, com_b, fl_b, to_b;
    logic [63:0] cc_a, rc_a;
    logic [3:0]  cc_b, rc_b;

    mc_stage_sequencer #(.N_STAGES(4), .COMMIT_DELAY(2), .TIMEOUT(5), .CNT_W(64)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .halt_req(halt_a), .stage_finish(fin_a),
        .flush(flush_a), .stage_valid(sv_a), .cur_stage(cs_a), .busy(busy_a), .retire(ret_a),
        .commit_valid(com_a), .flushed(fl_a), .timeout_err(to_a), .cycle_cnt(cc_a),
        .retire_cnt(rc_a));

    mc_stage_sequencer #(.N_STAGES(4), .COMMIT_DELAY(0), .TIMEOUT(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .halt_req(halt_b), .stage_finish(fin_b),
        .flush(flush_b), .stage_valid(sv_b), .cur_stage(cs_b), .busy(busy_b), .retire(ret_b),
        .commit_valid(com_b), .flushed(fl_b), .timeout_err(to_b), .cycle_cnt(cc_b),
        .retire_cnt(rc_b));

    typedef struct {int cyc; logic [63:0] val;} ev_t;
    ev_t q_sv[2][$];
    ev_t q_ret[2][$];
    ev_t q_com[2][$];
    ev_t q_fl[2][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode_a = 0, mode_b = 0;
    logic [3:0] seen_a = 4'h0, seen_b = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Stage responder: 0 none, 1 finish one cycle after valid, 2 all ones,
    // 3 like 1 but stage 1 never finishes.
    function automatic logic [3:0] resp(input int mode, input logic [3:0] seen);
        case (mode)
            1: return seen;
            2: return 4'hF;
            3: return seen & 4'b1101;
            default: return 4'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        seen_a = sv_a;
        seen_b = sv_b;
    end
    always @(posedge clk) begin
        #2;
        fin_a = resp(mode_a, seen_a);
        fin_b = resp(mode_b, seen_b);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int d, input int c, input logic [63:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        case (kind)
            0: q_sv[d].push_back(e);
            1: q_ret[d].push_back(e);
            2: q_com[d].push_back(e);
            default: q_fl[d].push_back(e);
        endcase
    endtask

    task automatic pop_ev(input int kind, input int d, output ev_t e, output bit ok);
        ok = 1'b0;
        e.cyc = 0;
        e.val = '0;
        case (kind)
            0: if (q_sv[d].size() > 0) begin e = q_sv[d].pop_front(); ok = 1'b1; end
            1: if (q_ret[d].size() > 0) begin e = q_ret[d].pop_front(); ok = 1'b1; end
            2: if (q_com[d].size() > 0) begin e = q_com[d].pop_front(); ok = 1'b1; end
            default: if (q_fl[d].size() > 0) begin e = q_fl[d].pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic mon_one(input int d, input int kind, input string nm,
                           input logic pulse, input logic [63:0] v);
        ev_t e;
        bit ok;
        if (!pulse) return;
        pop_ev(kind, d, e, ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL d%0d %s: unexpected pulse at cycle %0d value %0d, expected none",
                     d, nm, cyc, v);
        end else begin
            chk($sformatf("d%0d %s cycle", d, nm), 64'(cyc), 64'(e.cyc));
            chk($sformatf("d%0d %s value", d, nm), v, e.val);
            if (kind == 1 || kind == 3)
                $display("d%0d %s at cycle %0d cnt=%0d", d, nm, cyc, v);
        end
    endtask

    // Monitor: every output pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        mon_one(0, 0, "stage_valid", |sv_a, {60'd0, sv_a});
        mon_one(0, 1, "retire", ret_a, rc_a);
        mon_one(0, 2, "commit_valid", com_a, 64'd1);
        mon_one(0, 3, "flushed", fl_a, rc_a);
        mon_one(1, 0, "stage_valid", |sv_b, {60'd0, sv_b});
        mon_one(1, 1, "retire", ret_b, {60'd0, rc_b});
        mon_one(1, 2, "commit_valid", com_b, 64'd1);
        mon_one(1, 3, "flushed", fl_b, {60'd0, rc_b});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int s;
        rst = 1'b0;
        start_a = 0; halt_a = 0; flush_a = 0;
        start_b = 0; halt_b = 0; flush_b = 0;
        fin_a = 4'h0; fin_b = 4'h0;
        tick(); tick();
        chk("reset busy_a", busy_a, 0);
        chk("reset stage_valid_a", sv_a, 0);
        chk("reset cur_stage_a", cs_a, 0);
        chk("reset cycle_cnt_a", cc_a, 0);
        chk("reset retire_cnt_a", rc_a, 0);
        chk("reset timeout_err_a", to_a, 0);
        chk("reset busy_b", busy_b, 0);
        chk("reset retire_cnt_b", rc_b, 0);
        rst = 1'b1;
        tick();

        // 1: one-cycle finish latency, 3 instructions, halt after the third.
        mode_a = 1; start_a = 1; s = cyc + 1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) push(0, 0, s + 8*r + 2*k, 64'(1 << k));
            push(1, 0, s + 8*r + 8, 64'(r + 1));
            push(2, 0, s + 8*r + 10, 64'd1);
        end
        tick(); start_a = 0;
        repeat (16) tick();
        halt_a = 1;
        repeat (8) tick();
        chk("t1 busy after halt", busy_a, 0);
        chk("t1 retire_cnt", rc_a, 3);
        chk("t1 cycle_cnt", cc_a, 24);
        chk("t1 cur_stage", cs_a, 0);
        halt_a = 0;
        repeat (3) tick();
        chk("t1 cycle_cnt frozen", cc_a, 24);

        // 2: resume from HALT with zero-latency stages, two instructions.
        mode_a = 2; start_a = 1; s = cyc + 1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push(0, 0, s + 4*r + k, 64'(1 << k));
            push(1, 0, s + 4*r + 4, 64'(4 + r));
            push(2, 0, s + 4*r + 6, 64'd1);
        end
        tick(); start_a = 0;
        repeat (4) tick();
        halt_a = 1;
        repeat (4) tick();
        chk("t2 busy after halt", busy_a, 0);
        chk("t2 retire_cnt", rc_a, 5);
        chk("t2 cycle_cnt", cc_a, 32);
        halt_a = 0;

        // 3: flush at stage 2 (ignored while stage 2 unfinished), then flush+halt at stage 3.
        mode_a = 1; start_a = 1; s = cyc + 1;
        push(0, 0, s, 64'd1);      push(0, 0, s + 2, 64'd2);  push(0, 0, s + 4, 64'd4);
        push(0, 0, s + 6, 64'd1);  push(0, 0, s + 8, 64'd2);  push(0, 0, s + 10, 64'd4);
        push(0, 0, s + 12, 64'd8);
        push(3, 0, s + 6, 64'd5);  push(3, 0, s + 14, 64'd5);
        tick(); start_a = 0;
        repeat (4) tick();
        flush_a = 1;
        tick();
        chk("t3 flush w/o finish ignored", cs_a, 2);
        tick(); flush_a = 0;
        chk("t3 retire_cnt after flush", rc_a, 5);
        repeat (7) tick();
        flush_a = 1; halt_a = 1;
        tick(); flush_a = 0; halt_a = 0;
        chk("t3 busy after flush+halt", busy_a, 0);
        chk("t3 retire_cnt", rc_a, 5);
        chk("t3 cycle_cnt", cc_a, 46);

        // 5: watchdog on stage 1, resume, then async reset mid-WAIT.
        mode_a = 3; start_a = 1; s = cyc + 1;
        push(0, 0, s, 64'd1); push(0, 0, s + 2, 64'd2);
        tick(); start_a = 0;
        repeat (7) tick();
        chk("t5 no timeout yet", to_a, 0);
        chk("t5 busy while waiting", busy_a, 1);
        chk("t5 cur_stage stuck", cs_a, 1);
        tick();
        chk("t5 timeout_err", to_a, 1);
        chk("t5 halted", busy_a, 0);
        chk("t5 cycle_cnt", cc_a, 54);
        chk("t5 retire_cnt", rc_a, 5);
        mode_a = 1; start_a = 1; s = cyc + 1;
        push(0, 0, s, 64'd1); push(0, 0, s + 2, 64'd2); push(0, 0, s + 4, 64'd4);
        tick(); start_a = 0;
        repeat (5) tick();
        mode_a = 0;
        repeat (2) tick();
        chk("t5 timeout_err sticky", to_a, 1);
        chk("t5 busy resumed", busy_a, 1);
        chk("t5 cur_stage resumed", cs_a, 2);
        #2 rst = 1'b0;
        #1;
        chk("t5 async reset busy", busy_a, 0);
        chk("t5 async reset cur_stage", cs_a, 0);
        chk("t5 async reset timeout_err", to_a, 0);
        chk("t5 async reset cycle_cnt", cc_a, 0);
        chk("t5 async reset retire_cnt", rc_a, 0);
        tick(); rst = 1'b1;
        tick();

        // 6: 4-bit counters wrap, same-cycle commit, zero-latency stages.
        mode_b = 2; start_b = 1; s = cyc + 1;
        for (int r = 0; r < 17; r++) begin
            for (int k = 0; k < 4; k++) push(0, 1, s + 4*r + k, 64'(1 << k));
            push(1, 1, s + 4*r + 4, 64'((r + 1) % 16));
            push(2, 1, s + 4*r + 4, 64'd1);
        end
        tick(); start_b = 0;
        repeat (64) tick();
        halt_b = 1;
        repeat (4) tick();
        chk("t6 busy after halt", busy_b, 0);
        chk("t6 retire_cnt wrapped", rc_b, 1);
        chk("t6 cycle_cnt wrapped", cc_b, 4);
        halt_b = 0;

        // Watchdog disabled: a stuck stage just keeps waiting.
        mode_b = 3; start_b = 1; s = cyc + 1;
        push(0, 1, s, 64'd1); push(0, 1, s + 2, 64'd2);
        tick(); start_b = 0;
        repeat (20) tick();
        chk("t6 no watchdog timeout_err", to_b, 0);
        chk("t6 no watchdog busy", busy_b, 1);
        chk("t6 no watchdog cur_stage", cs_b, 1);

        tick();
        chk("d0 events outstanding", 64'(q_sv[0].size() + q_ret[0].size() + q_com[0].size() + q_fl[0].size()), 0);
        chk("d1 events outstanding", 64'(q_sv[1].size() + q_ret[1].size() + q_com[1].size() + q_fl[1].size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
